ur_cmd_bank: RTL and testbench
==============================

UR_CMD_BANK -- requirements
Module: ur_cmd_bank

Interface
REQ-001 Parameter N_REGS, default 8: number of user-register fields.
REQ-002 Parameter REG_W, default 16: width of each field in bits.
REQ-003 Parameter STABLE_CYC, default 4, range 1..255: cycles the input bus must hold unchanged before it is accepted.
REQ-004 Parameter MAX_VAL, default all-ones, N_REGS*REG_W bits: per-field upper limit, field k in bits [(k+1)*REG_W-1 : k*REG_W].
REQ-005 clk  in  1  single clock; all logic SHALL run on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 user_register_i  in  N_REGS*REG_W  raw register bus from the SPI slave; field k occupies bits [(k+1)*REG_W-1 : k*REG_W].
REQ-008 cmd_update_disable  in  1  high while an acquisition frame runs; the active bank SHALL NOT change while it is high.
REQ-009 ur_o  out  N_REGS*REG_W  active register bank, same field layout as user_register_i.
REQ-010 ur_update  out  1  one-cycle pulse in the cycle ur_o takes new contents.
REQ-011 ur_changed  out  N_REGS  bit k high when field k differed in the last commit; valid with ur_update and held until the next commit.
REQ-012 ur_version  out  8  commit counter; increments on each ur_update and wraps 255->0.
REQ-013 ur_pending  out  1  high in SETTLE and PENDING.

Function
REQ-014 The block SHALL register user_register_i into a shadow register each cycle, so the shadow lags the input by one cycle.
REQ-015 IDLE: while shadow == ur_o, stay; on shadow != ur_o, go to SETTLE with the stability counter cleared.
REQ-016 SETTLE: the counter SHALL increment each cycle the shadow is unchanged and clear on any shadow change; at STABLE_CYC go to PENDING; if the shadow returns to equal ur_o, go to IDLE.
REQ-017 PENDING: a change to the shadow SHALL return to SETTLE with the counter cleared; otherwise, when cmd_update_disable is low, go to APPLY.
REQ-018 APPLY (one cycle): ur_o <= shadow, ur_changed <= per-field inequality, ur_update = 1, ur_version += 1, then go to IDLE.
REQ-019 Minimum latency from the last input change to ur_update SHALL be 1 + STABLE_CYC + 1 cycles with cmd_update_disable low.
REQ-020 A change while APPLY is active SHALL be captured by the shadow and handled from IDLE on the next cycle; no input edge is lost.
REQ-021 cmd_update_disable rising in the same cycle the FSM enters PENDING SHALL block the apply; the FSM waits in PENDING.
REQ-022 Field comparison SHALL be unsigned at REG_W bits.

Reset
REQ-023 rst_n low SHALL clear asynchronously: shadow, ur_o, ur_changed, ur_version and the counter to 0; ur_update, ur_pending and ur_err to 0; state to IDLE.
REQ-024 Reset asserted in any state, including APPLY, SHALL suppress any ur_update pulse in that cycle.
REQ-025 After reset release, a nonzero input SHALL be processed as a normal change from IDLE.

Configuration
REQ-026 Macro UR_RANGE_CHECK_EN defined: adds output ur_err (1 bit, sticky until reset).
REQ-027 With UR_RANGE_CHECK_EN, on PENDING->APPLY the block SHALL check every field; if any field > MAX_VAL, then no commit occurs, ur_err is set, and the FSM enters REJECT.
REQ-028 The REJECT state SHALL be left for SETTLE on the next shadow change.
REQ-029 Without UR_RANGE_CHECK_EN: no ur_err port, no REJECT state, MAX_VAL ignored.

Structure
REQ-030 Shared package ur_pkg SHALL hold the FSM state enumeration (IDLE, SETTLE, PENDING, APPLY, REJECT) and the version width constant (8).
REQ-031 A single sub-module ur_field_cmp (one field: inequality bit plus over-limit bit) SHALL be instantiated N_REGS times by generate.

Verification (N_REGS=8, REG_W=16, STABLE_CYC=4)
REQ-032 Reset, then field7=0x1234 held, disable low -> ur_update pulses 6 cycles after the input edge; ur_o[127:112]=0x1234; ur_changed=8'h80; ur_version=1.
REQ-033 Field0 toggles 0x0001 and 0x0002 every 2 cycles for 20 cycles, then holds 0x0002 -> no ur_update during toggling; exactly one ur_update after the hold, ur_o field0=0x0002.
REQ-034 cmd_update_disable high, fields 3 and 5 changed -> ur_pending=1 and ur_o unchanged for 100 cycles; disable low -> ur_update next cycle after APPLY entry, ur_changed=8'h28.
REQ-035 256 commits of alternating values -> ur_version wraps to 0 on the 256th commit.
REQ-036 UR_RANGE_CHECK_EN, MAX_VAL field1=0x00FF, field1 written 0x0100 -> no ur_update, ur_err=1 and stays; then field1=0x0010 -> commit occurs, ur_err still 1.
REQ-037 rst_n asserted during APPLY -> ur_update stays 0 in that cycle, all outputs zero asynchronously.

Source files
------------

// File: rtl/ur_pkg.sv
// Shared types for the user-register command bank: FSM states, version and
// stability-counter widths.
package ur_pkg;
  localparam int UR_VER_W = 8;
  localparam int UR_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    PENDING,
    APPLY,
    REJECT
  } ur_state_e;
endpackage

// File: rtl/ur_field_cmp.sv
// One register field: differs-from-active bit and above-limit bit (unsigned).
module ur_field_cmp #(
  parameter int REG_W = 16
) (
  input  logic [REG_W-1:0] shadow_fld,
  input  logic [REG_W-1:0] active_fld,
  input  logic [REG_W-1:0] limit_fld,
  output logic             diff,
  output logic             over
);
  assign diff = shadow_fld != active_fld;
  assign over = shadow_fld > limit_fld;
endmodule

// File: rtl/ur_cmd_bank.sv
// Debounced user-register bank: the SPI register image is committed to ur_o only
// after it has been stable and no acquisition frame is running.
// Optional range check with sticky ur_err: define UR_RANGE_CHECK_EN.
module ur_cmd_bank
  import ur_pkg::*;
#(
  parameter int                       N_REGS     = 8,
  parameter int                       REG_W      = 16,
  parameter int                       STABLE_CYC = 4,
  parameter logic [N_REGS*REG_W-1:0]  MAX_VAL    = '1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REGS*REG_W-1:0]    user_register_i,
  input  logic                       cmd_update_disable,
  output logic [N_REGS*REG_W-1:0]    ur_o,
  output logic                       ur_update,
  output logic [N_REGS-1:0]          ur_changed,
  output logic [UR_VER_W-1:0]        ur_version,
  output logic                       ur_pending
`ifdef UR_RANGE_CHECK_EN
  ,
  output logic                       ur_err
`endif
);
  localparam int                BUS_W      = N_REGS * REG_W;
  localparam logic [UR_CNT_W:0] STABLE_LIM = (UR_CNT_W + 1)'(STABLE_CYC);

  ur_state_e             state, state_d;
  logic [BUS_W-1:0]      shadow;
  logic [UR_CNT_W-1:0]   cnt, cnt_d;
  logic [UR_CNT_W:0]     cnt_inc;
  logic [N_REGS-1:0]     diff, over;
  logic                  shadow_chg, shadow_dirty, stable_done;
  logic                  commit, reject, range_bad;

  for (genvar k = 0; k < N_REGS; k++) begin : g_fld
    ur_field_cmp #(.REG_W(REG_W)) u_cmp (
      .shadow_fld (shadow[k*REG_W +: REG_W]),
      .active_fld (ur_o[k*REG_W +: REG_W]),
      .limit_fld  (MAX_VAL[k*REG_W +: REG_W]),
      .diff       (diff[k]),
      .over       (over[k])
    );
  end

`ifdef UR_RANGE_CHECK_EN
  assign range_bad = |over;
`else
  logic unused_cfg;
  assign range_bad  = 1'b0;
  assign unused_cfg = ^{over, reject};
`endif

  // shadow_chg: the shadow takes a different value at the coming edge.
  assign shadow_chg   = user_register_i != shadow;
  assign shadow_dirty = |diff;
  assign cnt_inc      = {1'b0, cnt} + (UR_CNT_W + 1)'(1);
  assign stable_done  = cnt_inc == STABLE_LIM;

  // cnt counts consecutive edges with an unchanged shadow. It is zero in IDLE,
  // so IDLE and SETTLE share one rule; the IDLE detection edge is the first
  // stable edge, which gives the 1 + STABLE_CYC + 1 latency to APPLY.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    commit  = 1'b0;
    reject  = 1'b0;
    case (state)
      IDLE, SETTLE: begin
        if (!shadow_dirty) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (shadow_chg) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else if (stable_done) begin
          state_d = PENDING;
          cnt_d   = '0;
        end else begin
          state_d = SETTLE;
          cnt_d   = cnt_inc[UR_CNT_W-1:0];
        end
      end
      PENDING: begin
        if (shadow_chg) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else if (!cmd_update_disable) begin
          if (range_bad) begin
            state_d = REJECT;
            reject  = 1'b1;
          end else begin
            state_d = APPLY;
            commit  = 1'b1;
          end
        end
      end
      APPLY: state_d = IDLE;
`ifdef UR_RANGE_CHECK_EN
      REJECT: begin
        if (shadow_chg) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The bank is loaded on the edge entering APPLY, so the APPLY cycle is the
  // one where ur_o, ur_changed and ur_version show the new commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shadow     <= '0;
      ur_o       <= '0;
      ur_changed <= '0;
      ur_version <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      shadow <= user_register_i;
      if (commit) begin
        ur_o       <= shadow;
        ur_changed <= diff;
        ur_version <= ur_version + UR_VER_W'(1);
      end
    end
  end

`ifdef UR_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ur_err <= 1'b0;
    else if (reject) ur_err <= 1'b1;
  end
`endif

  assign ur_update  = state == APPLY;
  assign ur_pending = (state == SETTLE) || (state == PENDING);
endmodule

// File: tb/tb_ur_cmd_bank.sv
// Bench for ur_cmd_bank: directed scenarios plus randomized traffic against a
// stability-window reference model. Build with UR_RANGE_CHECK_EN for the range test.
module tb_ur_cmd_bank;
  localparam int N  = 8;
  localparam int RW = 16;
  localparam int S  = 4;
  localparam int BW = N * RW;
  localparam logic [BW-1:0] MAXV = {{6{16'hFFFF}}, 16'h00FF, 16'hFFFF};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] uri = '0;
  logic          dis = 1'b0;
  logic [BW-1:0] ur_o;
  logic          ur_update;
  logic [N-1:0]  ur_changed;
  logic [7:0]    ur_version;
  logic          ur_pending;
`ifdef UR_RANGE_CHECK_EN
  logic          ur_err;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  ur_cmd_bank #(.N_REGS(N), .REG_W(RW), .STABLE_CYC(S), .MAX_VAL(MAXV)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .user_register_i    (uri),
    .cmd_update_disable (dis),
    .ur_o               (ur_o),
    .ur_update          (ur_update),
    .ur_changed         (ur_changed),
    .ur_version         (ur_version),
    .ur_pending         (ur_pending)
`ifdef UR_RANGE_CHECK_EN
    ,
    .ur_err             (ur_err)
`endif
  );

  // Reference model: a commit happens on an edge where the sampled image has
  // been unchanged for at least S edges, differs from the bank, will not change
  // now, frames are not blocking, and the previous edge was not itself a commit.
  logic [BW-1:0] m_sh, m_o;
  logic [N-1:0]  m_chgd;
  logic [7:0]    m_ver;
  logic          m_upd, m_rej, m_err;
  int            m_run;

  function automatic logic [N-1:0] field_diff(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [N-1:0] d;
    for (int k = 0; k < N; k++) d[k] = a[k*RW +: RW] != b[k*RW +: RW];
    return d;
  endfunction

`ifdef UR_RANGE_CHECK_EN
  function automatic logic any_over(input logic [BW-1:0] a);
    logic o;
    o = 1'b0;
    for (int k = 0; k < N; k++) if (a[k*RW +: RW] > MAXV[k*RW +: RW]) o = 1'b1;
    return o;
  endfunction
  wire m_bad = any_over(m_sh);
`else
  wire m_bad = 1'b0;
`endif

  wire m_chg    = uri != m_sh;
  wire m_ready  = !dis && !m_chg && (m_sh != m_o) && (m_run >= S) && !m_upd && !m_rej;
  wire m_commit = m_ready && !m_bad;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sh <= '0; m_o <= '0; m_chgd <= '0; m_ver <= '0;
      m_upd <= 1'b0; m_rej <= 1'b0; m_err <= 1'b0; m_run <= 0;
    end else begin
      m_sh  <= uri;
      m_run <= m_chg ? 0 : ((m_run < 1000) ? m_run + 1 : m_run);
      m_upd <= m_commit;
      if (m_commit) begin
        m_o    <= m_sh;
        m_chgd <= field_diff(m_sh, m_o);
        m_ver  <= m_ver + 8'd1;
      end
      if (m_ready && m_bad) begin
        m_rej <= 1'b1;
        m_err <= 1'b1;
      end else if (m_chg) begin
        m_rej <= 1'b0;
      end
    end
  end

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h0001;
      2:       return 16'h0002;
      3:       return 16'h00FF;
      4:       return 16'h0100;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    uri   = '0;
    dis   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; uri = '0; dis = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if ({ur_o, ur_changed, ur_version, ur_update, ur_pending} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got o=%h chg=%h ver=%0d upd=%b pend=%b, want all 0",
               ur_o, ur_changed, ur_version, ur_update, ur_pending);
    end
`ifdef UR_RANGE_CHECK_EN
    vecs++;
    if (ur_err !== 1'b0) begin errs++; $display("FAIL reset_err: got %b want 0", ur_err); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    uri[127:112] = 16'h1234;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      vecs++;
      if (ur_update !== (c == 6)) begin
        errs++; $display("FAIL latency_update cyc %0d: got %b want %b", c, ur_update, c == 6);
      end
      vecs++;
      if (ur_pending !== (c >= 2 && c <= 5)) begin
        errs++; $display("FAIL latency_pending cyc %0d: got %b want %b", c, ur_pending, c >= 2 && c <= 5);
      end
    end
    vecs++;
    if (ur_o[127:112] !== 16'h1234) begin errs++; $display("FAIL latency_field7: got %h want 1234", ur_o[127:112]); end
    vecs++;
    if (ur_changed !== 8'h80) begin errs++; $display("FAIL latency_changed: got %h want 80", ur_changed); end
    vecs++;
    if (ur_version !== 8'd1) begin errs++; $display("FAIL latency_version: got %0d want 1", ur_version); end
  endtask

  task automatic test_glitch();
    int ups_toggle, ups_hold;
    ups_toggle = 0; ups_hold = 0;
    for (int c = 0; c < 20; c++) begin
      uri[15:0] = ((c / 2) % 2 == 1) ? 16'h0002 : 16'h0001;
      @(negedge clk);
      if (ur_update) ups_toggle++;
    end
    uri[15:0] = 16'h0002;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ur_update) ups_hold++;
    end
    vecs++;
    if (ups_toggle !== 0) begin errs++; $display("FAIL glitch_toggle_updates: got %0d want 0", ups_toggle); end
    vecs++;
    if (ups_hold !== 1) begin errs++; $display("FAIL glitch_hold_updates: got %0d want 1", ups_hold); end
    vecs++;
    if (ur_o[15:0] !== 16'h0002) begin errs++; $display("FAIL glitch_field0: got %h want 0002", ur_o[15:0]); end
    vecs++;
    if (ur_changed !== 8'h01) begin errs++; $display("FAIL glitch_changed: got %h want 01", ur_changed); end
  endtask

  task automatic test_disable();
    logic [BW-1:0] prev;
    logic [7:0]    ver0;
    prev = ur_o;
    ver0 = ur_version;
    dis  = 1'b1;
    uri[3*RW +: RW] = 16'hAAAA;
    uri[5*RW +: RW] = 16'h5555;
    repeat (5) @(negedge clk);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      vecs++;
      if (ur_pending !== 1'b1 || ur_o !== prev || ur_update !== 1'b0) begin
        errs++;
        $display("FAIL disable_hold cyc %0d: got pend=%b upd=%b o=%h, want pend=1 upd=0 o=%h",
                 c, ur_pending, ur_update, ur_o, prev);
      end
    end
    dis = 1'b0;
    @(negedge clk);
    vecs++;
    if (ur_update !== 1'b1) begin errs++; $display("FAIL disable_release_update: got %b want 1", ur_update); end
    vecs++;
    if (ur_changed !== 8'h28) begin errs++; $display("FAIL disable_changed: got %h want 28", ur_changed); end
    vecs++;
    if (ur_version !== ver0 + 8'd1) begin errs++; $display("FAIL disable_version: got %0d want %0d", ur_version, ver0 + 8'd1); end
    vecs++;
    if (ur_o[5*RW +: RW] !== 16'h5555 || ur_o[3*RW +: RW] !== 16'hAAAA) begin
      errs++; $display("FAIL disable_fields: got f5=%h f3=%h want 5555 aaaa", ur_o[5*RW +: RW], ur_o[3*RW +: RW]);
    end
  endtask

  // Each new value is driven during the previous APPLY cycle, so every
  // commit also exercises a change arriving while APPLY is active.
  task automatic test_wrap();
    int   timeouts, late;
    logic [7:0] v255;
    bit   got;
    timeouts = 0; late = 0; v255 = '0;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      uri[2*RW +: RW] = (i % 2 == 1) ? 16'h005A : 16'h00A5;
      got = 1'b0;
      for (int c = 1; c <= 12 && !got; c++) begin
        @(negedge clk);
        if (ur_update) begin
          got = 1'b1;
          if (c != 6) late++;
        end
      end
      if (!got) timeouts++;
      if (i == 254) v255 = ur_version;
    end
    vecs++;
    if (timeouts !== 0) begin errs++; $display("FAIL wrap_timeouts: got %0d want 0", timeouts); end
    vecs++;
    if (late !== 0) begin errs++; $display("FAIL wrap_latency: got %0d commits off 6 cycles, want 0", late); end
    vecs++;
    if (v255 !== 8'd255) begin errs++; $display("FAIL wrap_v255: got %0d want 255", v255); end
    vecs++;
    if (ur_version !== 8'd0) begin errs++; $display("FAIL wrap_v256: got %0d want 0", ur_version); end
  endtask

  task automatic test_reset_in_apply();
    uri[6*RW +: RW] = 16'h0F0F;
    repeat (5) @(negedge clk);
    vecs++;
    if (ur_update !== 1'b0) begin errs++; $display("FAIL rstapply_pre: got %b want 0", ur_update); end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vecs++;
    if ({ur_o, ur_changed, ur_version, ur_update, ur_pending} !== '0) begin
      errs++;
      $display("FAIL rstapply_async: got o=%h chg=%h ver=%0d upd=%b pend=%b, want all 0",
               ur_o, ur_changed, ur_version, ur_update, ur_pending);
    end
    @(negedge clk);
    vecs++;
    if (ur_update !== 1'b0) begin errs++; $display("FAIL rstapply_cycle: got %b want 0", ur_update); end
    uri = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_after_reset();
    int at;
    at = 0;
    uri[4*RW +: RW] = 16'hBEEF;
    for (int c = 1; c <= 12 && at == 0; c++) begin
      @(negedge clk);
      if (ur_update) at = c;
    end
    vecs++;
    if (at !== 6) begin errs++; $display("FAIL after_reset_latency: got %0d want 6", at); end
    vecs++;
    if (ur_changed !== 8'h10 || ur_version !== 8'd1) begin
      errs++; $display("FAIL after_reset_commit: got chg=%h ver=%0d want 10/1", ur_changed, ur_version);
    end
  endtask

`ifdef UR_RANGE_CHECK_EN
  task automatic test_range();
    int ups;
    bit got;
    ups = 0;
    do_reset();
    uri[31:16] = 16'h0100;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ur_update) ups++;
    end
    vecs++;
    if (ups !== 0) begin errs++; $display("FAIL range_no_commit: got %0d updates want 0", ups); end
    vecs++;
    if (ur_err !== 1'b1) begin errs++; $display("FAIL range_err_set: got %b want 1", ur_err); end
    uri[31:16] = 16'h0010;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (ur_update) got = 1'b1;
    end
    vecs++;
    if (!got || ur_o[31:16] !== 16'h0010) begin
      errs++; $display("FAIL range_recommit: got upd=%b f1=%h want 1/0010", got, ur_o[31:16]);
    end
    vecs++;
    if (ur_err !== 1'b1) begin errs++; $display("FAIL range_err_sticky: got %b want 1", ur_err); end
  endtask
`endif

  task automatic test_random(input int cycles);
    int f;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      vecs++;
      if (ur_update !== m_upd) begin errs++; $display("FAIL rand_update cyc %0d: got %b want %b", c, ur_update, m_upd); end
      vecs++;
      if (ur_o !== m_o) begin errs++; $display("FAIL rand_bank cyc %0d: got %h want %h", c, ur_o, m_o); end
      vecs++;
      if (ur_changed !== m_chgd) begin errs++; $display("FAIL rand_changed cyc %0d: got %h want %h", c, ur_changed, m_chgd); end
      vecs++;
      if (ur_version !== m_ver) begin errs++; $display("FAIL rand_version cyc %0d: got %0d want %0d", c, ur_version, m_ver); end
`ifdef UR_RANGE_CHECK_EN
      vecs++;
      if (ur_err !== m_err) begin errs++; $display("FAIL rand_err cyc %0d: got %b want %b", c, ur_err, m_err); end
`endif
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      if ($urandom_range(0, 11) == 0) dis = ~dis;
      if ($urandom_range(0, 5) == 0) begin
        f = $urandom_range(0, N - 1);
        uri[f*RW +: RW] = pick();
      end
    end
    dis   = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_disable();
    test_wrap();
    test_reset_in_apply();
    test_after_reset();
`ifdef UR_RANGE_CHECK_EN
    test_range();
`endif
    test_random(2000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
